// File: rtl/tc_to_sm_conv_pkg.sv
// Shared constants and the two's-complement to sign-magnitude mapping
// used by the converter and by sign-magnitude consumers such as the comparator.
package tc_to_sm_conv_pkg;

   localparam int unsigned TC_WIDTH = 8;

   localparam logic [TC_WIDTH-1:0] TC_MOST_NEG = {1'b1, {(TC_WIDTH-1){1'b0}}};
   localparam logic [TC_WIDTH-1:0] SM_SAT_CODE = '1;

   // The most negative value has no sign-magnitude form; it clamps to -(2^(W-1)-1).
   function automatic logic [TC_WIDTH-1:0] tc2sm(input logic [TC_WIDTH-1:0] value);
      logic [TC_WIDTH-1:0] neg;
      neg = ~value + 1'b1;
      if (!value[TC_WIDTH-1])
         return value;
      else if (value == TC_MOST_NEG)
         return SM_SAT_CODE;
      else
         return {1'b1, neg[TC_WIDTH-2:0]};
   endfunction

endpackage

// File: rtl/sm_fifo.sv
// Synchronous FIFO with registered storage; the head entry is presented
// directly from the storage array so it holds stable while not popped.
module sm_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_LVL);
   assign empty   = (count == '0);
   // A full FIFO refuses a push even when it is popped in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tc_to_sm_conv.sv
// Streaming two's-complement to sign-magnitude converter with an output FIFO
// and running statistics (saturation count, largest accepted magnitude).
module tc_to_sm_conv
   import tc_to_sm_conv_pkg::*;
#(
   parameter int unsigned WIDTH = TC_WIDTH,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] sat_count,
   output logic [WIDTH-2:0] max_mag
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             fifo_full;
   logic             fifo_empty;
   logic             accept;
   logic             take;
   logic             sat_in;
   logic [WIDTH-1:0] neg_data;
   logic [WIDTH-1:0] sm_code;
   logic [WIDTH-2:0] mag;

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;

   always_comb begin
      sat_in   = (in_data == MOST_NEG);
      neg_data = ~in_data + 1'b1;
      sm_code  = in_data;
      if (in_data[WIDTH-1])
         sm_code = sat_in ? '1 : {1'b1, neg_data[WIDTH-2:0]};
      mag = sm_code[WIDTH-2:0];
   end

   sm_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (accept),
      .pop     (take),
      .wr_data (sm_code),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A clear coinciding with an accept restarts the statistics from that sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
         max_mag   <= '0;
      end else if (stat_clr) begin
         sat_count <= (accept && sat_in) ? CNT_W'(1) : '0;
         max_mag   <= accept ? mag : '0;
      end else if (accept) begin
         if (sat_in && (sat_count != '1))
            sat_count <= sat_count + 1'b1;
         if (mag > max_mag)
            max_mag <= mag;
      end
   end

endmodule

// File: tb/tb_tc_to_sm_conv.sv
// Self-checking bench for tc_to_sm_conv: directed vector table, hand-written
// backpressure/saturation/reset sequences, and a randomized queue-model run.
module tb_tc_to_sm_conv;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       stat_clr = 1'b0;
   logic [7:0] in_data = 8'h00;

   logic       in_ready, out_valid;
   logic [7:0] out_data;
   logic [7:0] sat_count;
   logic [6:0] max_mag;

   logic       in_ready2, out_valid2;
   logic [7:0] out_data2;
   logic [1:0] sat_count2;
   logic [6:0] max_mag2;

   int n_checks = 0;
   int n_errors = 0;

   tc_to_sm_conv #(.WIDTH(8), .DEPTH(D), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .stat_clr(stat_clr), .sat_count(sat_count),
      .max_mag(max_mag)
   );

   tc_to_sm_conv #(.WIDTH(8), .DEPTH(D), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .stat_clr(stat_clr), .sat_count(sat_count2),
      .max_mag(max_mag2)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: signed value -> sign and clamped magnitude, by plain arithmetic.
   function automatic int ref_val(input logic [7:0] x);
      return (x >= 8'd128) ? int'(x) - 256 : int'(x);
   endfunction

   function automatic int ref_mag(input logic [7:0] x);
      int v;
      v = ref_val(x);
      if (v < 0) v = -v;
      return (v > 127) ? 127 : v;
   endfunction

   function automatic bit ref_sat(input logic [7:0] x);
      return (-ref_val(x)) > 127;
   endfunction

   function automatic logic [7:0] ref_conv(input logic [7:0] x);
      return (ref_val(x) < 0) ? 8'(128 + ref_mag(x)) : x;
   endfunction

   typedef struct {
      logic [7:0] din;
      logic [7:0] dout;
      logic [7:0] sat;
      logic [6:0] mx;
   } vec_t;

   vec_t tbl [9];

   logic [7:0] q[$];
   int         m_sat;
   int         m_max;
   bit         acc, pop;
   int         s_exp;

   initial begin
      tbl[0] = '{8'h05, 8'h05, 8'd0, 7'h05};
      tbl[1] = '{8'hFB, 8'h85, 8'd0, 7'h05};
      tbl[2] = '{8'h03, 8'h03, 8'd0, 7'h05};
      tbl[3] = '{8'hC0, 8'hC0, 8'd0, 7'h40};
      tbl[4] = '{8'h80, 8'hFF, 8'd1, 7'h7F};
      tbl[5] = '{8'h00, 8'h00, 8'd1, 7'h7F};
      tbl[6] = '{8'h7F, 8'h7F, 8'd1, 7'h7F};
      tbl[7] = '{8'hFF, 8'h81, 8'd1, 7'h7F};
      tbl[8] = '{8'h81, 8'hFF, 8'd1, 7'h7F};

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'h00);
      check("rst_sat_count", {24'd0, sat_count}, 32'd0);
      check("rst_max_mag", {25'd0, max_mag}, 32'd0);
      step();
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Conversion table, one sample at a time
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = tbl[i].din;
         step();
         in_valid = 1'b0;
         check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("tbl%0d_data", i), {24'd0, out_data}, {24'd0, tbl[i].dout});
         check($sformatf("tbl%0d_sat", i), {24'd0, sat_count}, {24'd0, tbl[i].sat});
         check($sformatf("tbl%0d_max", i), {25'd0, max_mag}, {25'd0, tbl[i].mx});
         step();
         check($sformatf("tbl%0d_drained", i), {31'd0, out_valid}, 32'd0);
      end

      // Backpressure: fill, hold a 5th sample, then drain in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data = 8'h01; step();
      in_data = 8'h02; step();
      in_data = 8'hFF; step();
      in_data = 8'h7F; step();
      check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_full_head", {24'd0, out_data}, 32'h01);
      in_data = 8'h10;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_stall_data", {24'd0, out_data}, 32'h01);
      end
      out_ready = 1'b1;
      step();
      check("bp_pop_full_data", {24'd0, out_data}, 32'h02);
      check("bp_pop_full_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_out3", {24'd0, out_data}, 32'h81);
      step();
      check("bp_out4", {24'd0, out_data}, 32'h7F);
      step();
      check("bp_out5", {24'd0, out_data}, 32'h10);
      check("bp_out5_valid", {31'd0, out_valid}, 32'd1);
      step();
      check("bp_empty", {31'd0, out_valid}, 32'd0);

      // Saturation counter: clear with concurrent push, then run past CNT_W=2 limit
      stat_clr = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h80;
      step();
      stat_clr = 1'b0;
      check("clr_push_sat", {24'd0, sat_count}, 32'd1);
      check("clr_push_sat2", {30'd0, sat_count2}, 32'd1);
      check("clr_push_max", {25'd0, max_mag}, 32'h7F);
      for (int i = 2; i <= 5; i++) begin
         step();
         check("sat_count", {24'd0, sat_count}, i);
         check("sat_count_c2", {30'd0, sat_count2}, (i > 3) ? 3 : i);
      end
      in_valid = 1'b0;
      step();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      check("clr_only_sat", {24'd0, sat_count}, 32'd0);
      check("clr_only_max", {25'd0, max_mag}, 32'd0);

      // Reset asserted mid-burst
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data = 8'h11; step();
      in_data = 8'h22; step();
      in_data = 8'h33; step();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_data", {24'd0, out_data}, 32'h00);
      check("mid_rst_max", {25'd0, max_mag}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("mid_rst_release_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_release_ready", {31'd0, in_ready}, 32'd1);

      // Randomized run against a queue model
      m_sat = 0;
      m_max = 0;
      for (int i = 0; i < 2000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
         out_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 3) == 0);
         stat_clr  = ($urandom_range(0, 31) == 0);

         check("rnd_in_ready", {31'd0, in_ready}, {31'd0, q.size() < D});
         check("rnd_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         if (q.size() != 0)
            check("rnd_out_data", {24'd0, out_data}, {24'd0, q[0]});
         s_exp = (m_sat > 255) ? 255 : m_sat;
         check("rnd_sat", {24'd0, sat_count}, s_exp);
         s_exp = (m_sat > 3) ? 3 : m_sat;
         check("rnd_sat_c2", {30'd0, sat_count2}, s_exp);
         check("rnd_max", {25'd0, max_mag}, m_max);

         acc = in_valid && (q.size() < D);
         pop = out_ready && (q.size() != 0);
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(ref_conv(in_data));
         if (stat_clr) begin
            m_sat = (acc && ref_sat(in_data)) ? 1 : 0;
            m_max = acc ? ref_mag(in_data) : 0;
         end else if (acc) begin
            if (ref_sat(in_data)) m_sat++;
            if (ref_mag(in_data) > m_max) m_max = ref_mag(in_data);
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
